// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 IV and round constants, controller state type and the
// message-schedule sigma functions shared by the schedule controller.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_ADD   = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

  localparam logic [5:0] LAST_ROUND = 6'd63;

  // H0 occupies the most significant lane
  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] SHA256_K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// sha256_k_rom: combinational lookup of the SHA-256 round constant K[idx].
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [31:0] k
);

  assign k = SHA256_K[idx];

endmodule

// File: rtl/sha256_sched_ctrl.sv
// sha256_sched_ctrl: accepts 512-bit blocks, sequences an external round engine,
// generates W[t] from a sliding 16-word window and chains H across blocks.
// Defining SHA256_SCHED_BLKCNT_EN adds the blk_cnt block counter output.
module sha256_sched_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned BE_WORDS = 32'd1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         eng_init,
  output logic [255:0] eng_h_init,
  output logic         eng_step,
  output logic [31:0]  eng_w,
  output logic [31:0]  eng_k,
  output logic [5:0]   eng_round,
  input  logic [255:0] eng_state,
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ready
`ifdef SHA256_SCHED_BLKCNT_EN
  ,
  output logic [15:0]  blk_cnt
`endif
);

  sched_state_e     state_r;
  sched_state_e     state_s;
  logic [15:0][31:0] win_r;
  logic [15:0][31:0] blk_words_s;
  logic [31:0]      w_new_s;
  logic [31:0]      w_next_s;
  logic [31:0]      k_s;
  logic [5:0]       round_s;
  logic [5:0]       round_r;
  logic             last_r;
  logic [255:0]     h_r;
  logic [255:0]     h_sum_s;
  logic [255:0]     h_load_s;
  logic             accept_s;

  logic             blk_ready_r;
  logic             eng_init_r;
  logic [255:0]     eng_h_init_r;
  logic             eng_step_r;
  logic [31:0]      eng_w_r;
  logic [31:0]      eng_k_r;
  logic [255:0]     digest_r;
  logic             digest_valid_r;

  assign accept_s = (state_r == ST_IDLE) && blk_valid;

  sha256_k_rom u_k_rom (
    .idx (round_s),
    .k   (k_s)
  );

  // Next-state decode of the block sequencing FSM
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (blk_valid) state_s = ST_LOAD; else state_s = ST_IDLE;
      ST_LOAD:  state_s = ST_ROUND;
      ST_ROUND: if (round_r == LAST_ROUND) state_s = ST_ADD; else state_s = ST_ROUND;
      ST_ADD:   if (last_r) state_s = ST_DONE; else state_s = ST_IDLE;
      ST_DONE:  if (digest_ready) state_s = ST_IDLE; else state_s = ST_DONE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Word unpacking, schedule expansion, chaining sums and look-ahead round values
  always_comb begin
    blk_words_s = '0;
    for (int i = 0; i < 16; i++) begin
      if (BE_WORDS != 32'd0) blk_words_s[i] = blk_data[511-32*i -: 32];
      else                   blk_words_s[i] = blk_data[32*i +: 32];
    end
    // win_r[0] is W[t]; the sum below is W[t+16]
    w_new_s  = sigma1(win_r[14]) + win_r[9] + sigma0(win_r[1]) + win_r[0];
    h_load_s = blk_first ? SHA256_IV : h_r;
    h_sum_s  = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum_s[255-32*i -: 32] = h_r[255-32*i -: 32] + eng_state[255-32*i -: 32];
    end
    if (state_s == ST_ROUND) begin
      round_s  = (state_r == ST_ROUND) ? (round_r + 6'd1) : 6'd0;
      w_next_s = (state_r == ST_ROUND) ? win_r[1] : win_r[0];
    end else begin
      round_s  = 6'd0;
      w_next_s = 32'd0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Schedule window, last-block flag and chaining value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_r  <= '0;
      last_r <= 1'b0;
      h_r    <= SHA256_IV;
    end else if (accept_s) begin
      win_r  <= blk_words_s;
      last_r <= blk_last;
      if (blk_first) h_r <= SHA256_IV;
      else           h_r <= h_r;
    end else if (state_r == ST_ROUND) begin
      win_r <= {w_new_s, win_r[15:1]};
    end else if (state_r == ST_ADD) begin
      h_r <= h_sum_s;
    end else begin
      h_r <= h_r;
    end
  end

  // Output registers are loaded from the next state so they align with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_ready_r    <= 1'b1;
      eng_init_r     <= 1'b0;
      eng_h_init_r   <= '0;
      eng_step_r     <= 1'b0;
      round_r        <= 6'd0;
      eng_w_r        <= 32'd0;
      eng_k_r        <= 32'd0;
      digest_valid_r <= 1'b0;
      digest_r       <= '0;
    end else begin
      blk_ready_r    <= (state_s == ST_IDLE);
      eng_init_r     <= (state_s == ST_LOAD);
      eng_h_init_r   <= (state_s == ST_LOAD) ? h_load_s : '0;
      eng_step_r     <= (state_s == ST_ROUND);
      round_r        <= round_s;
      eng_w_r        <= w_next_s;
      eng_k_r        <= (state_s == ST_ROUND) ? k_s : 32'd0;
      digest_valid_r <= (state_s == ST_DONE);
      digest_r       <= (state_s == ST_DONE) ? ((state_r == ST_ADD) ? h_sum_s : h_r) : '0;
    end
  end

  assign blk_ready    = blk_ready_r;
  assign eng_init     = eng_init_r;
  assign eng_h_init   = eng_h_init_r;
  assign eng_step     = eng_step_r;
  assign eng_round    = round_r;
  assign eng_w        = eng_w_r;
  assign eng_k        = eng_k_r;
  assign digest       = digest_r;
  assign digest_valid = digest_valid_r;

`ifdef SHA256_SCHED_BLKCNT_EN
  logic [15:0] blk_cnt_r;

  // Blocks completed since the message start, wrapping at 16 bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     blk_cnt_r <= 16'd0;
    else if (accept_s && blk_first) blk_cnt_r <= 16'd0;
    else if (state_r == ST_ADD)     blk_cnt_r <= blk_cnt_r + 16'd1;
    else                            blk_cnt_r <= blk_cnt_r;
  end

  assign blk_cnt = blk_cnt_r;
`endif

endmodule

// File: doc/sha256_sched_ctrl.md
SHA256_SCHED_CTRL -- requirements
Module: sha256_sched_ctrl

Interface
REQ-001 SHALL have parameter BE_WORDS, default 1; 1: message word 0 = blk_data[511:480]; 0: word 0 = blk_data[31:0].
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port blk_valid  in  1  512-bit block offered.
REQ-005 SHALL have port blk_ready  out  1  controller can accept a block.
REQ-006 SHALL have port blk_data  in  512  message block.
REQ-007 SHALL have port blk_first  in  1  block starts a new message; chaining value reloads IV.
REQ-008 SHALL have port blk_last  in  1  block ends the message; digest is produced.
REQ-009 SHALL have port eng_init  out  1  one-cycle load of eng_h_init into engine a..h.
REQ-010 SHALL have port eng_h_init  out  256  current chaining value H0..H7, H0 in [255:224].
REQ-011 SHALL have port eng_step  out  1  engine performs one round this cycle.
REQ-012 SHALL have port eng_w  out  32  W[t] for current round.
REQ-013 SHALL have port eng_k  out  32  K[t] for current round.
REQ-014 SHALL have port eng_round  out  6  round index t.
REQ-015 SHALL have port eng_state  in  256  engine a..h, valid the cycle after the 64th step.
REQ-016 SHALL have port digest  out  256  final hash, H0 in [255:224].
REQ-017 SHALL have port digest_valid  out  1  digest available.
REQ-018 SHALL have port digest_ready  in  1  consumer accepts digest.

Function
REQ-019 SHALL implement FSM IDLE -> LOAD -> ROUND -> ADD -> (DONE if last else IDLE); DONE -> IDLE on digest_valid&&digest_ready.
REQ-020 SHALL assert blk_ready only in IDLE; a block is accepted on blk_valid&&blk_ready; blk_valid in other states is ignored.
REQ-021 On accept SHALL latch the 16 words into a 16x32 schedule window and latch blk_last; if blk_first, H SHALL load the SHA-256 IV before LOAD.
REQ-022 LOAD SHALL last one cycle with eng_init=1 and eng_h_init=H.
REQ-023 ROUND SHALL last exactly 64 cycles with eng_step=1, eng_round=0..63, eng_k=K[t].
REQ-024 eng_w SHALL be window word t for t<16, else sigma1(W[t-2])+W[t-7]+sigma0(W[t-15])+W[t-16] mod 2^32; window shifts one word per step.
REQ-025 ADD SHALL last one cycle: H[i] <= H[i]+eng_state word i, each lane mod 2^32.
REQ-026 Block latency accept -> ADD complete SHALL be 66 cycles; digest_valid SHALL rise the cycle after ADD for last blocks.
REQ-027 In DONE digest SHALL equal H and stay stable until handshake; blk_ready SHALL stay 0.
REQ-028 eng_init, eng_step SHALL be 0 outside LOAD/ROUND; eng_w, eng_k, eng_round SHALL be 0 outside ROUND.
REQ-029 A non-first block SHALL chain from current H; a non-first block after reset SHALL chain from IV.
REQ-030 Block with blk_first=blk_last=1 SHALL be a complete single-block message.

Reset
REQ-031 reset low SHALL asynchronously force IDLE, H=IV, window=0, all outputs 0 except blk_ready (1 after release).
REQ-032 reset mid-ROUND or in DONE SHALL discard the block/digest; no digest_valid SHALL follow.

Configuration
REQ-033 With SHA256_SCHED_BLKCNT_EN defined SHALL add output blk_cnt[15:0]: +1 per ADD, wraps at 0xFFFF->0, cleared on blk_first accept and reset; without it the port and counter SHALL not exist and behaviour is otherwise identical.

Structure
REQ-034 Package sha256_pkg SHALL hold IV constants, the 64-entry K table, FSM state typedef, sigma0/sigma1 functions.
REQ-035 Sub-module sha256_k_rom (combinational, 6-bit index -> 32-bit K) SHALL supply eng_k.

Verification
REQ-036 "abc" padded, first=last=1 with reference engine model -> round0 eng_w=0x61626380, eng_k=0x428a2f98; round63 eng_k=0xc67178f2; digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-037 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" as 2 blocks -> no digest after block 1, digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-038 Hold digest_ready=0 for 5 cycles in DONE -> digest stable, blk_ready=0 throughout, IDLE one cycle after ready.
REQ-039 Assert reset at round 30 -> outputs 0 immediately, blk_ready=1 after release, no digest_valid; subsequent "abc" gives REQ-036 digest.
REQ-040 blk_valid held high during ROUND -> no second accept until IDLE; with SHA256_SCHED_BLKCNT_EN, blk_cnt=2 after REQ-037 sequence.
